// File: rtl/sample_conditioner_pkg.sv
// Shared types, default widths and the saturation helper for the sample conditioner.
package sample_conditioner_pkg;

    // DC blocker mode: INIT waits for the first average to preload the integrator.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } dc_state_t;

    localparam int DEF_SAMPLE_WIDTH = 12;
    localparam int DEF_DATA_W       = 8;
    localparam int DEF_DECIM_LOG2   = 2;
    localparam int DEF_DC_SHIFT     = 8;
    localparam int DEF_GAIN_SHIFT   = 0;

    // Derived widths for the default configuration.
    localparam int ACC_W = DEF_SAMPLE_WIDTH + DEF_DECIM_LOG2;
    localparam int DC_W  = DEF_SAMPLE_WIDTH + DEF_DC_SHIFT;
    localparam int AC_W  = DEF_SAMPLE_WIDTH + 1;

    // Clamp a signed value into the two's complement range of 'width' bits.
    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                       input int width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/sample_conditioner_dc_blocker.sv
// Leaky-integrator DC removal. The first average after reset only preloads the
// integrator; every later average produces one AC sample.
module dc_blocker
    import sample_conditioner_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
    parameter int DC_SHIFT     = DEF_DC_SHIFT
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [SAMPLE_WIDTH-1:0]        avg,
    input  logic                           avg_valid,
    output logic signed [SAMPLE_WIDTH:0]   ac,
    output logic                           ac_valid
);

    localparam int DC_BITS = SAMPLE_WIDTH + DC_SHIFT;

    dc_state_t                   state;
    logic [DC_BITS-1:0]          dc_acc;
    logic [SAMPLE_WIDTH-1:0]     dc_mean;
    logic signed [SAMPLE_WIDTH:0] diff;

    // Current DC estimate and the difference of the new average from it.
    always_comb begin
        dc_mean = SAMPLE_WIDTH'(dc_acc >> DC_SHIFT);
        diff    = $signed({1'b0, avg}) - $signed({1'b0, dc_mean});
    end

    // Preload on the first average, then track DC and emit the residual.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= INIT;
            dc_acc   <= '0;
            ac       <= '0;
            ac_valid <= 1'b0;
        end else begin
            ac_valid <= 1'b0;
            if (avg_valid) begin
                if (state == INIT) begin
                    dc_acc <= DC_BITS'(avg) << DC_SHIFT;
                    state  <= RUN;
                end else begin
                    ac       <= diff;
                    ac_valid <= 1'b1;
                    // diff is sign-extended; the sum stays non-negative.
                    dc_acc   <= dc_acc + DC_BITS'(diff);
                end
            end
        end
    end

endmodule

// File: rtl/sample_conditioner.sv
// ADC sample conditioner: block-average decimation, DC removal, power-of-two gain,
// saturation and a single-entry valid/ready output register.
module sample_conditioner
    import sample_conditioner_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int DECIM_LOG2   = DEF_DECIM_LOG2,
    parameter int DC_SHIFT     = DEF_DC_SHIFT,
    parameter int GAIN_SHIFT   = DEF_GAIN_SHIFT
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [SAMPLE_WIDTH-1:0] adc_data,
    input  logic                    adc_valid,
    output logic [DATA_W-1:0]       out_sample,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overrun,
    output logic [7:0]              sat_count
);

    localparam int ACC_BITS = SAMPLE_WIDTH + DECIM_LOG2;
    localparam int CNT_W    = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << DECIM_LOG2) - 1);

    logic [ACC_BITS-1:0]          acc;
    logic [ACC_BITS-1:0]          sum;
    logic [CNT_W-1:0]             dcnt;
    logic [SAMPLE_WIDTH-1:0]      avg;
    logic                         avg_valid;
    logic signed [SAMPLE_WIDTH:0] ac;
    logic                         ac_valid;
    logic signed [31:0]           ac_wide;
    logic signed [31:0]           scaled;
    logic signed [31:0]           sat_val;
    logic                         clipped;

    // Running group sum including the current sample, and the scaled/saturated AC value.
    always_comb begin
        sum     = acc + ACC_BITS'(adc_data);
        ac_wide = 32'(ac);
        scaled  = (ac_wide <<< GAIN_SHIFT) >>> (SAMPLE_WIDTH - DATA_W);
        sat_val = sat_signed(scaled, DATA_W);
        clipped = (sat_val != scaled);
    end

    // Stage 1: accumulate strobes; the group-closing sample is part of the average.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc       <= '0;
            dcnt      <= '0;
            avg       <= '0;
            avg_valid <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            if (adc_valid) begin
                if (dcnt == CNT_LAST) begin
                    avg       <= SAMPLE_WIDTH'(sum >> DECIM_LOG2);
                    avg_valid <= 1'b1;
                    acc       <= '0;
                    dcnt      <= '0;
                end else begin
                    acc  <= sum;
                    dcnt <= dcnt + 1'b1;
                end
            end
        end
    end

    // Stage 2: DC removal.
    dc_blocker #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .DC_SHIFT     (DC_SHIFT)
    ) u_dc_blocker (
        .clk       (clk),
        .resetn    (resetn),
        .avg       (avg),
        .avg_valid (avg_valid),
        .ac        (ac),
        .ac_valid  (ac_valid)
    );

    // Stage 3: output register; a new sample always wins over a pending transfer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_sample <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
            sat_count  <= '0;
        end else begin
            if (ac_valid) begin
                out_sample <= sat_val[DATA_W-1:0];
                out_valid  <= 1'b1;
                if (out_valid && !out_ready) begin
                    overrun <= 1'b1;
                end
                if (clipped && (sat_count != 8'hFF)) begin
                    sat_count <= sat_count + 8'd1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sample_conditioner.sv
// Bench for sample_conditioner: two configurations driven by the same stimulus and
// checked every cycle against a behavioural model, plus hand-computed expectations.
module tb_sample_conditioner;

    logic        clk = 1'b0;
    logic        resetn;
    logic [11:0] adc_data;
    logic        adc_valid;
    logic        out_ready;

    logic [7:0]  out_sample0, out_sample1;
    logic        out_valid0, out_valid1;
    logic        overrun0, overrun1;
    logic [7:0]  sat_count0, sat_count1;

    int total = 0;
    int bad   = 0;
    int obs0[$];
    int obs1[$];

    // Behavioural model state, one entry per instance.
    int m_acc[2];
    int m_cnt[2];
    int m_dc[2];
    int m_out[2];
    int m_sat[2];
    bit m_run[2];
    bit m_ov[2];
    bit m_ovr[2];
    bit pend_v[2][2];
    int pend_y[2][2];
    bit pend_c[2][2];

    sample_conditioner #(
        .SAMPLE_WIDTH(12), .DATA_W(8), .DECIM_LOG2(2), .DC_SHIFT(8), .GAIN_SHIFT(0)
    ) dut0 (
        .clk(clk), .resetn(resetn), .adc_data(adc_data), .adc_valid(adc_valid),
        .out_sample(out_sample0), .out_valid(out_valid0), .out_ready(out_ready),
        .overrun(overrun0), .sat_count(sat_count0)
    );

    sample_conditioner #(
        .SAMPLE_WIDTH(12), .DATA_W(8), .DECIM_LOG2(0), .DC_SHIFT(8), .GAIN_SHIFT(2)
    ) dut1 (
        .clk(clk), .resetn(resetn), .adc_data(adc_data), .adc_valid(adc_valid),
        .out_sample(out_sample1), .out_valid(out_valid1), .out_ready(out_ready),
        .overrun(overrun1), .sat_count(sat_count1)
    );

    always #5 clk = ~clk;

    function automatic int dl_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic int gs_of(input int i);
        return (i == 0) ? 0 : 2;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_acc[i] = 0; m_cnt[i] = 0; m_dc[i] = 0; m_out[i] = 0; m_sat[i] = 0;
            m_run[i] = 0; m_ov[i] = 0; m_ovr[i] = 0;
            for (int k = 0; k < 2; k++) begin
                pend_v[i][k] = 0; pend_y[i][k] = 0; pend_c[i][k] = 0;
            end
        end
    endtask

    // One clock edge of the model: a completed group is visible at the output two
    // edges after the edge that takes its last strobe.
    task automatic model_step(input int i, input bit v, input int d, input bit rdy);
        int avg, ac, y, ys;
        if (pend_v[i][0]) begin
            if (m_ov[i] && !rdy) m_ovr[i] = 1;
            m_ov[i]  = 1;
            m_out[i] = pend_y[i][0];
            if (pend_c[i][0] && m_sat[i] < 255) m_sat[i]++;
        end else if (m_ov[i] && rdy) begin
            m_ov[i] = 0;
        end
        pend_v[i][0] = pend_v[i][1]; pend_y[i][0] = pend_y[i][1]; pend_c[i][0] = pend_c[i][1];
        pend_v[i][1] = 0;
        if (v) begin
            m_acc[i] += d;
            m_cnt[i]++;
            if (m_cnt[i] == (1 << dl_of(i))) begin
                avg = m_acc[i] >> dl_of(i);
                m_acc[i] = 0;
                m_cnt[i] = 0;
                if (!m_run[i]) begin
                    m_dc[i]  = avg * 256;
                    m_run[i] = 1;
                end else begin
                    ac = avg - (m_dc[i] / 256);
                    m_dc[i] += ac;
                    y  = (ac * (1 << gs_of(i))) >>> 4;
                    ys = (y > 127) ? 127 : ((y < -128) ? -128 : y);
                    pend_v[i][1] = 1;
                    pend_y[i][1] = ys;
                    pend_c[i][1] = (ys != y);
                end
            end
        end
    endtask

    task automatic chk_inst(input int i, input logic v, input logic [7:0] s,
                            input logic o, input logic [7:0] c);
        chk($sformatf("out_valid[%0d]", i), int'(v), int'(m_ov[i]));
        chk($sformatf("overrun[%0d]", i), int'(o), int'(m_ovr[i]));
        chk($sformatf("sat_count[%0d]", i), int'(c), m_sat[i]);
        if (m_ov[i]) chk($sformatf("out_sample[%0d]", i), int'($signed(s)), m_out[i]);
    endtask

    task automatic compare_all();
        chk_inst(0, out_valid0, out_sample0, overrun0, sat_count0);
        chk_inst(1, out_valid1, out_sample1, overrun1, sat_count1);
    endtask

    // Drive one cycle of inputs, advance the model, then compare after the edge.
    task automatic tick(input bit v, input int d, input bit rdy);
        if (out_valid0 && rdy) obs0.push_back(int'($signed(out_sample0)));
        if (out_valid1 && rdy) obs1.push_back(int'($signed(out_sample1)));
        adc_valid = v;
        adc_data  = 12'(d);
        out_ready = rdy;
        model_step(0, v, d, rdy);
        model_step(1, v, d, rdy);
        @(negedge clk);
        compare_all();
    endtask

    task automatic apply_reset();
        adc_valid = 0;
        out_ready = 1;
        resetn    = 0;
        model_clear();
        @(negedge clk);
        resetn = 1;
        compare_all();
    endtask

    initial begin
        int base, d;
        resetn = 1; adc_valid = 0; adc_data = 0; out_ready = 1;
        @(negedge clk);
        apply_reset();
        chk("reset out_sample", int'(out_sample0), 0);
        chk("reset out_valid", int'(out_valid0), 0);
        chk("reset overrun", int'(overrun0), 0);
        chk("reset sat_count", int'(sat_count0), 0);

        // Constant mid-scale: first group only preloads, then nine zero outputs.
        obs0.delete();
        repeat (40) tick(1, 2048, 1);
        repeat (4) tick(0, 0, 1);
        chk("const count", obs0.size(), 9);
        foreach (obs0[k]) chk("const value", obs0[k], 0);
        chk("const sat_count", int'(sat_count0), 0);

        // Step of +256 from a settled 2048.
        obs0.delete();
        repeat (8) tick(1, 2304, 1);
        repeat (4) tick(0, 0, 1);
        chk("step count", obs0.size(), 2);
        if (obs0.size() == 2) begin
            chk("step first", obs0[0], 16);
            chk("step second", obs0[1], 15);
        end

        // Full-scale alternation after a 2048 preload.
        apply_reset();
        obs0.delete();
        repeat (4) tick(1, 2048, 1);
        for (int g = 0; g < 4; g++) repeat (4) tick(1, (g % 2 == 1) ? 0 : 4095, 1);
        repeat (4) tick(0, 0, 1);
        chk("clip count", obs0.size(), 4);
        if (obs0.size() == 4) begin
            chk("clip g0", obs0[0], 127);
            chk("clip g1", obs0[1], -128);
            chk("clip g2", obs0[2], 127);
            chk("clip g3", obs0[3], -128);
        end
        chk("clip sat_count", int'(sat_count0), 3);

        // Two loads with no consumer, then a single accept.
        apply_reset();
        repeat (4) tick(1, 2048, 1);
        repeat (4) tick(1, 2048, 0);
        repeat (4) tick(1, 2304, 0);
        repeat (3) tick(0, 0, 0);
        chk("ovr overrun", int'(overrun0), 1);
        chk("ovr out_valid", int'(out_valid0), 1);
        chk("ovr out_sample", int'($signed(out_sample0)), 16);
        tick(0, 0, 1);
        chk("ovr drained", int'(out_valid0), 0);

        // No decimation, gain x4: step of +10 gives 2.
        apply_reset();
        obs1.delete();
        repeat (4) tick(1, 1000, 1);
        tick(1, 1010, 1);
        repeat (4) tick(0, 0, 1);
        chk("gain count", obs1.size(), 4);
        chk("gain value", (obs1.size() > 0) ? obs1[obs1.size() - 1] : -999, 2);

        // Reset in the middle of a group, then preload and latency.
        apply_reset();
        obs0.delete();
        repeat (2) tick(1, 3000, 1);
        apply_reset();
        repeat (4) tick(1, 3000, 1);
        repeat (3) tick(0, 0, 1);
        chk("midreset no output", obs0.size(), 0);
        repeat (4) tick(1, 3000, 1);
        chk("latency edge0", int'(out_valid0), 0);
        tick(0, 0, 1);
        chk("latency edge1", int'(out_valid0), 0);
        tick(0, 0, 1);
        chk("latency edge2", int'(out_valid0), 1);
        chk("midreset value", int'($signed(out_sample0)), 0);

        // Randomized traffic, backpressure and occasional resets.
        base = 2048;
        for (int c = 0; c < 1500; c++) begin
            if (c % 150 == 0) base = int'($urandom_range(0, 4095));
            if ($urandom_range(0, 499) == 0) begin
                apply_reset();
            end else begin
                d = base + int'($urandom_range(0, 400)) - 200;
                if (d < 0) d = 0;
                if (d > 4095) d = 4095;
                tick($urandom_range(0, 9) < 7, d, $urandom_range(0, 9) < 6);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
